fft_bfly_r2: RTL and testbench

FFT_BFLY_R2 -- requirements
Module: fft_bfly_r2

---
 rtl/fft_bfly_r2.sv | 144 ++++++++++++++
 tb/tb_fft_bfly_r2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_r2.sv
// Radix-2 butterfly back end: aligns A with an external W*B product, rounds the
// product to Q1.17 and forms A+WB / A-WB with optional /2 scaling and saturation.
module fft_bfly_r2 #(
    parameter int MUL_LAT = 6,
    parameter int SCALE   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [17:0] a_real,
    input  logic [17:0] a_imag,
    input  logic [35:0] prod_real,
    input  logic [35:0] prod_imag,
    input  logic        clr_ovf,
    output logic        out_valid,
    output logic [17:0] x0_real,
    output logic [17:0] x0_imag,
    output logic [17:0] x1_real,
    output logic [17:0] x1_imag,
    output logic        ovf
);

    logic [17:0]        aReDly_q [MUL_LAT];
    logic [17:0]        aImDly_q [MUL_LAT];
    logic               vldDly_q [MUL_LAT];

    logic signed [18:0] pRe_d, pIm_d, pRe_q, pIm_q;
    logic [17:0]        rARe_q, rAIm_q;
    logic               rVld_q;

    logic signed [19:0] sumRe, sumIm, difRe, difIm;
    logic [18:0]        x0ReSat, x0ImSat, x1ReSat, x1ImSat;
    logic [17:0]        x0Re_d, x0Im_d, x1Re_d, x1Im_d;
    logic [17:0]        x0Re_q, x0Im_q, x1Re_q, x1Im_q;
    logic               anySat;
    logic               outVld_q;
    logic               ovf_d, ovf_q;

    // Returns {saturated, clamped Q1.17 value}; scaling rounds half up before clamping.
    function automatic logic [18:0] scaleSat(input logic signed [19:0] v);
        logic signed [19:0] t;
        t = (SCALE != 0) ? ((v + 20'sd1) >>> 1) : v;
        if (t > 20'sd131071)
            return {1'b1, 18'h1FFFF};
        else if (t < -20'sd131072)
            return {1'b1, 18'h20000};
        else
            return {1'b0, t[17:0]};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                aReDly_q[i] <= '0;
                aImDly_q[i] <= '0;
                vldDly_q[i] <= 1'b0;
            end
        end else begin
            aReDly_q[0] <= a_real;
            aImDly_q[0] <= a_imag;
            vldDly_q[0] <= in_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                aReDly_q[i] <= aReDly_q[i-1];
                aImDly_q[i] <= aImDly_q[i-1];
                vldDly_q[i] <= vldDly_q[i-1];
            end
        end
    end

    // The 36-bit wrap of the rounding add cannot disturb the kept bits [35:17].
    always_comb begin
        pRe_d = 19'(($signed(prod_real) + 36'sd65536) >>> 17);
        pIm_d = 19'(($signed(prod_imag) + 36'sd65536) >>> 17);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pRe_q  <= '0;
            pIm_q  <= '0;
            rARe_q <= '0;
            rAIm_q <= '0;
            rVld_q <= 1'b0;
        end else begin
            pRe_q  <= pRe_d;
            pIm_q  <= pIm_d;
            rARe_q <= aReDly_q[MUL_LAT-1];
            rAIm_q <= aImDly_q[MUL_LAT-1];
            rVld_q <= vldDly_q[MUL_LAT-1];
        end
    end

    always_comb begin
        sumRe   = 20'($signed(rARe_q)) + 20'(pRe_q);
        sumIm   = 20'($signed(rAIm_q)) + 20'(pIm_q);
        difRe   = 20'($signed(rARe_q)) - 20'(pRe_q);
        difIm   = 20'($signed(rAIm_q)) - 20'(pIm_q);
        x0ReSat = scaleSat(sumRe);
        x0ImSat = scaleSat(sumIm);
        x1ReSat = scaleSat(difRe);
        x1ImSat = scaleSat(difIm);
        x0Re_d  = x0ReSat[17:0];
        x0Im_d  = x0ImSat[17:0];
        x1Re_d  = x1ReSat[17:0];
        x1Im_d  = x1ImSat[17:0];
        anySat  = x0ReSat[18] | x0ImSat[18] | x1ReSat[18] | x1ImSat[18];
    end

    // Saturation only counts on valid beats, and a new saturation beats a clear.
    always_comb begin
        ovf_d = ovf_q;
        if (rVld_q && anySat)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0Re_q   <= '0;
            x0Im_q   <= '0;
            x1Re_q   <= '0;
            x1Im_q   <= '0;
            outVld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            outVld_q <= rVld_q;
            ovf_q    <= ovf_d;
            if (rVld_q) begin
                x0Re_q <= x0Re_d;
                x0Im_q <= x0Im_d;
                x1Re_q <= x1Re_d;
                x1Im_q <= x1Im_d;
            end
        end
    end

    assign out_valid = outVld_q;
    assign x0_real   = x0Re_q;
    assign x0_imag   = x0Im_q;
    assign x1_real   = x1Re_q;
    assign x1_imag   = x1Im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Bench for fft_bfly_r2: one scaled and one unscaled instance share a scheduled
// stimulus stream; an arithmetic reference model predicts every output each cycle.
module tb_fft_bfly_r2;

    localparam int LAT  = 6;
    localparam int MAXN = 256;

    logic        clock = 1'b0;
    logic        reset, in_valid, clr_ovf;
    logic [17:0] a_real, a_imag;
    logic [35:0] prod_real, prod_imag;

    logic        u0Valid, u1Valid, u0Ovf, u1Ovf;
    logic [17:0] u0X0r, u0X0i, u0X1r, u0X1i;
    logic [17:0] u1X0r, u1X0i, u1X1r, u1X1i;

    always #5 clock = ~clock;

    fft_bfly_r2 #(.MUL_LAT(LAT), .SCALE(0)) u0 (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .a_real(a_real), .a_imag(a_imag),
        .prod_real(prod_real), .prod_imag(prod_imag), .clr_ovf(clr_ovf),
        .out_valid(u0Valid), .x0_real(u0X0r), .x0_imag(u0X0i),
        .x1_real(u0X1r), .x1_imag(u0X1i), .ovf(u0Ovf)
    );

    fft_bfly_r2 #(.MUL_LAT(LAT), .SCALE(1)) u1 (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .a_real(a_real), .a_imag(a_imag),
        .prod_real(prod_real), .prod_imag(prod_imag), .clr_ovf(clr_ovf),
        .out_valid(u1Valid), .x0_real(u1X0r), .x0_imag(u1X0i),
        .x1_real(u1X1r), .x1_imag(u1X1i), .ovf(u1Ovf)
    );

    // Schedule: entry m is what gets driven at negedge m.
    bit                 vld [MAXN];
    bit                 rstS [MAXN];
    bit                 clrS [MAXN];
    logic signed [17:0] aR [MAXN];
    logic signed [17:0] aI [MAXN];
    logic signed [35:0] pR [MAXN];
    logic signed [35:0] pI [MAXN];
    bit                 dirOn [MAXN];
    int                 dirInst [MAXN];
    int                 dirX0r [MAXN];
    int                 dirX1r [MAXN];
    int                 dirOvf [MAXN];
    int                 n = 0;

    longint expX [2][4];
    bit     expO [2];
    bit     expV;

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic addIdle(input bit c, input bit r);
        vld[n]   = 1'b0;
        aR[n]    = 18'($urandom);
        aI[n]    = 18'($urandom);
        pR[n]    = '0;
        pI[n]    = '0;
        clrS[n]  = c;
        rstS[n]  = r;
        dirOn[n] = 1'b0;
        n++;
    endtask

    task automatic addBeat(input longint ar, input longint ai, input longint pr, input longint pi,
                           input bit c, input bit r);
        vld[n]   = 1'b1;
        aR[n]    = 18'(ar);
        aI[n]    = 18'(ai);
        pR[n]    = 36'(pr);
        pI[n]    = 36'(pi);
        clrS[n]  = c;
        rstS[n]  = r;
        dirOn[n] = 1'b0;
        n++;
    endtask

    task automatic addDirected(input longint ar, input longint pr, input int inst,
                               input int x0r, input int x1r, input int ov);
        addBeat(ar, 0, pr, 0, 1'b0, 1'b0);
        dirOn[n-1]   = 1'b1;
        dirInst[n-1] = inst;
        dirX0r[n-1]  = x0r;
        dirX1r[n-1]  = x1r;
        dirOvf[n-1]  = ov;
    endtask

    task automatic addRandomBeat(input bit r);
        logic signed [34:0] tr, ti;
        tr = 35'({$urandom, $urandom});
        ti = 35'({$urandom, $urandom});
        addBeat(longint'(18'sh3FFFF & $urandom) - 131072, longint'($urandom_range(0, 262143)) - 131072,
                longint'(tr), longint'(ti), ($urandom_range(0, 19) == 0), r);
    endtask

    // Round half up to the 17-fraction-bit grid, then optional halving and clamp.
    function automatic longint finishRes(input longint s, input int scale, output bit sat);
        longint t;
        t   = (scale != 0) ? ((s + 1) >>> 1) : s;
        sat = 1'b0;
        if (t > 131071) begin
            t   = 131071;
            sat = 1'b1;
        end else if (t < -131072) begin
            t   = -131072;
            sat = 1'b1;
        end
        return t;
    endfunction

    // A beat reaches the output only if reset stays low for its whole 8-cycle trip.
    function automatic bit survives(input int k);
        if (k < 0 || k >= n || !vld[k]) return 1'b0;
        for (int j = k; j <= k + 7; j++)
            if (j < n && rstS[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelStep(input int m);
        bit     rNow, cNow, sat, anySat;
        int     k;
        longint pRe, pIm;
        longint raw [4];
        rNow = (m - 1 < n) ? rstS[m-1] : 1'b0;
        cNow = (m - 1 < n) ? clrS[m-1] : 1'b0;
        k    = m - 8;
        expV = !rNow && survives(k);
        for (int inst = 0; inst < 2; inst++) begin
            if (rNow) begin
                for (int f = 0; f < 4; f++) expX[inst][f] = 0;
                expO[inst] = 1'b0;
            end else if (expV) begin
                pRe    = (longint'(pR[k]) + 65536) >>> 17;
                pIm    = (longint'(pI[k]) + 65536) >>> 17;
                raw[0] = longint'(aR[k]) + pRe;
                raw[1] = longint'(aI[k]) + pIm;
                raw[2] = longint'(aR[k]) - pRe;
                raw[3] = longint'(aI[k]) - pIm;
                anySat = 1'b0;
                for (int f = 0; f < 4; f++) begin
                    expX[inst][f] = finishRes(raw[f], inst, sat);
                    anySat |= sat;
                end
                if (anySat)    expO[inst] = 1'b1;
                else if (cNow) expO[inst] = 1'b0;
            end else if (cNow) begin
                expO[inst] = 1'b0;
            end
        end
    endtask

    task automatic checkInst(input int inst, input int m);
        logic        v, o;
        logic [17:0] xv [4];
        int          k;
        string       nm [4];
        nm = '{"x0_real", "x0_imag", "x1_real", "x1_imag"};
        if (inst == 0) begin
            v = u0Valid; o = u0Ovf;
            xv[0] = u0X0r; xv[1] = u0X0i; xv[2] = u0X1r; xv[3] = u0X1i;
        end else begin
            v = u1Valid; o = u1Ovf;
            xv[0] = u1X0r; xv[1] = u1X0i; xv[2] = u1X1r; xv[3] = u1X1i;
        end
        checkOutput($sformatf("u%0d out_valid @%0d", inst, m), longint'(v), longint'(expV));
        for (int f = 0; f < 4; f++)
            checkOutput($sformatf("u%0d %s @%0d", inst, nm[f], m),
                        longint'($signed(xv[f])), expX[inst][f]);
        checkOutput($sformatf("u%0d ovf @%0d", inst, m), longint'(o), longint'(expO[inst]));
        k = m - 8;
        if (expV && dirOn[k] && dirInst[k] == inst) begin
            checkOutput($sformatf("u%0d directed x0_real beat %0d", inst, k),
                        longint'($signed(xv[0])), longint'(dirX0r[k]));
            checkOutput($sformatf("u%0d directed x1_real beat %0d", inst, k),
                        longint'($signed(xv[2])), longint'(dirX1r[k]));
            if (dirOvf[k] >= 0)
                checkOutput($sformatf("u%0d directed ovf beat %0d", inst, k),
                            longint'(o), longint'(dirOvf[k]));
        end
    endtask

    // Products are presented LAT cycles after their beat; unused slots carry noise.
    task automatic applyStimulus(input int m);
        int j;
        j = m - LAT;
        if (m < n) begin
            reset    = rstS[m];
            in_valid = vld[m];
            a_real   = aR[m];
            a_imag   = aI[m];
            clr_ovf  = clrS[m];
        end else begin
            reset    = 1'b0;
            in_valid = 1'b0;
            a_real   = 18'($urandom);
            a_imag   = 18'($urandom);
            clr_ovf  = 1'b0;
        end
        if (j >= 0 && j < n && vld[j]) begin
            prod_real = pR[j];
            prod_imag = pI[j];
        end else begin
            prod_real = {4'($urandom), $urandom};
            prod_imag = {4'($urandom), $urandom};
        end
    endtask

    initial begin
        int kSat2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        a_real    = '0;
        a_imag    = '0;
        prod_real = '0;
        prod_imag = '0;

        addIdle(1'b0, 1'b1);
        addIdle(1'b0, 1'b1);
        addIdle(1'b0, 1'b0);
        addIdle(1'b0, 1'b0);

        addDirected(1000, 500 * 131072, 1, 750, 250, 0);
        addDirected(0, 3 * 65536, 0, 2, -2, 0);
        addDirected(0, 65535, 0, 0, 0, -1);
        addDirected(-3, 0, 1, -1, -1, -1);
        addDirected(3, 0, 1, 2, 2, -1);
        for (int i = 0; i < 10; i++) addIdle(1'b0, 1'b0);

        addDirected(131071, 131071 * 131072, 0, 131071, 0, 1);
        for (int i = 0; i < 12; i++) addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) addIdle(1'b0, 1'b0);

        addDirected(-131072, 131071 * 131072, 0, -1, -131072, 1);
        for (int i = 0; i < 3; i++) addIdle(1'b0, 1'b0);
        kSat2 = n;
        addDirected(-131072, 131071 * 131072, 0, -1, -131072, 1);
        for (int i = 0; i < 6; i++) addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) addIdle(1'b0, 1'b0);
        addIdle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) addIdle(1'b0, 1'b0);
        if (clrS[kSat2 + 7] != 1'b1)
            $display("[TB] note: clear pulse not aligned with second saturating beat");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 7) addRandomBeat(1'b0);
            else                          addIdle(($urandom_range(0, 19) == 0), 1'b0);
        end
        for (int i = 0; i < 12; i++) addIdle(1'b0, 1'b0);

        for (int i = 0; i < 20; i++) addRandomBeat(i == 10 || i == 11);
        for (int i = 0; i < 12; i++) addIdle(1'b0, 1'b0);

        $display("[TB] schedule holds %0d cycles", n);

        for (int m = 0; m < n + 12; m++) begin
            @(negedge clock);
            if (m > 0) begin
                modelStep(m);
                checkInst(0, m);
                checkInst(1, m);
            end
            applyStimulus(m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
